// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences traps, mret and Zicsr requests onto the machine-mode
// CSR file port, one operation at a time, and redirects fetch on traps/mret.
module trap_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            commit_v_i,
  input  logic [5:0]      commit_exc_i,
  input  logic            commit_mret_i,
  input  logic [XLEN-1:0] commit_pc_i,
  input  logic [XLEN-1:0] commit_tval_i,
  output logic            commit_ready_o,
  input  logic            csr_req_v_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_adr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic            csr_nowrite_i,
  output logic            csr_ready_o,
  output logic            csr_done_o,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_err_o,
  output logic            exception_o,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mtval_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            write_v_o,
  output logic [11:0]     adr_write_o,
  output logic [11:0]     adr_read_o,
  output logic [XLEN-1:0] data_o,
  input  logic [XLEN-1:0] csr_data_i,
  input  logic [XLEN-1:0] mepc_q_i,
  input  logic [XLEN-1:0] mtvec_q_i,
  output logic            flush_o,
  output logic            redirect_v_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  typedef enum logic [3:0] {
    IDLE, T_READ, T_CAUSE, T_STATUS, M_READ, M_STATUS, C_READ, C_WRITE, REDIRECT
  } state_t;

  localparam logic [11:0] ADR_MSTATUS = 12'h300;

  state_t          state, state_next;

  logic            trap_req, mret_req, idle_ok;
  logic            take_trap, take_mret, take_csr;
  logic [3:0]      cause_d;
  logic [XLEN-1:0] tval_d;

  logic            mret_q;
  logic [3:0]      cause_q;
  logic [XLEN-1:0] tval_q, pc_q;
  logic [1:0]      op_q;
  logic [11:0]     adr_q;
  logic [XLEN-1:0] wdata_q;
  logic            nowrite_q;
  logic [XLEN-1:0] old_q;

  logic [XLEN-1:0] csr_new, status_trap, status_mret;
  logic            wr_attempt, adr_ro;

  // Request qualification and fixed-priority arbitration (trap > mret > CSR).
  always_comb begin
    trap_req  = commit_v_i && (|commit_exc_i);
    mret_req  = commit_v_i && commit_mret_i && !(|commit_exc_i);
    idle_ok   = (state == IDLE) && !reset;
    take_trap = idle_ok && trap_req;
    take_mret = idle_ok && mret_req;
    take_csr  = idle_ok && csr_req_v_i && !trap_req && !mret_req;
  end

  // Trap cause priority and the matching mtval source.
  always_comb begin
    cause_d = 4'd0;
    tval_d  = commit_tval_i;
    if (commit_exc_i[0]) begin
      cause_d = 4'd0;
    end else if (commit_exc_i[1]) begin
      cause_d = 4'd2;
    end else if (commit_exc_i[2]) begin
      cause_d = 4'd11;
      tval_d  = '0;
    end else if (commit_exc_i[3]) begin
      cause_d = 4'd3;
      tval_d  = commit_pc_i;
    end else if (commit_exc_i[5]) begin
      cause_d = 4'd6;
    end else if (commit_exc_i[4]) begin
      cause_d = 4'd4;
    end
  end

  // Updated mstatus images and Zicsr write value, all from the captured old value.
  always_comb begin
    status_trap         = old_q;
    status_trap[7]      = old_q[3];
    status_trap[3]      = 1'b0;
    status_trap[12:11]  = 2'b11;
    status_mret         = old_q;
    status_mret[3]      = old_q[7];
    status_mret[7]      = 1'b1;
    status_mret[12:11]  = 2'b11;
    unique case (op_q)
      2'b01:   csr_new = wdata_q;
      2'b11:   csr_new = old_q & ~wdata_q;
      default: csr_new = old_q | wdata_q;
    endcase
    wr_attempt = !nowrite_q;
    adr_ro     = (adr_q[11:10] == 2'b11);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Captured request fields and the old CSR value read during *_READ states.
  always_ff @(posedge clk) begin
    if (reset) begin
      mret_q    <= 1'b0;
      cause_q   <= '0;
      tval_q    <= '0;
      pc_q      <= '0;
      op_q      <= '0;
      adr_q     <= '0;
      wdata_q   <= '0;
      nowrite_q <= 1'b0;
      old_q     <= '0;
    end else begin
      if (take_trap) begin
        mret_q  <= 1'b0;
        cause_q <= cause_d;
        tval_q  <= tval_d;
        pc_q    <= commit_pc_i;
      end
      if (take_mret) mret_q <= 1'b1;
      if (take_csr) begin
        op_q      <= csr_op_i;
        adr_q     <= csr_adr_i;
        wdata_q   <= csr_wdata_i;
        nowrite_q <= csr_nowrite_i;
      end
      if (state == T_READ || state == M_READ || state == C_READ) old_q <= csr_data_i;
    end
  end

  // Next state and per-state CSR-file / pipeline outputs.
  always_comb begin
    state_next     = state;
    commit_ready_o = 1'b0;
    csr_ready_o    = 1'b0;
    csr_done_o     = 1'b0;
    csr_rdata_o    = '0;
    csr_err_o      = 1'b0;
    exception_o    = 1'b0;
    mcause_o       = '0;
    mtval_o        = '0;
    mepc_o         = '0;
    write_v_o      = 1'b0;
    adr_write_o    = '0;
    adr_read_o     = '0;
    data_o         = '0;
    flush_o        = 1'b0;
    redirect_v_o   = 1'b0;
    redirect_pc_o  = '0;
    unique case (state)
      IDLE: begin
        commit_ready_o = take_trap || take_mret;
        csr_ready_o    = take_csr;
        if (take_trap)      state_next = T_READ;
        else if (take_mret) state_next = M_READ;
        else if (take_csr)  state_next = C_READ;
      end
      T_READ: begin
        flush_o    = 1'b1;
        adr_read_o = ADR_MSTATUS;
        state_next = T_CAUSE;
      end
      T_CAUSE: begin
        // data_o stays 0: the CSR file ORs it into the trap CSRs this cycle.
        flush_o     = 1'b1;
        exception_o = 1'b1;
        mcause_o    = {{(XLEN-4){1'b0}}, cause_q};
        mtval_o     = tval_q;
        mepc_o      = pc_q;
        state_next  = T_STATUS;
      end
      T_STATUS: begin
        flush_o     = 1'b1;
        write_v_o   = 1'b1;
        adr_write_o = ADR_MSTATUS;
        data_o      = status_trap;
        state_next  = REDIRECT;
      end
      M_READ: begin
        flush_o    = 1'b1;
        adr_read_o = ADR_MSTATUS;
        state_next = M_STATUS;
      end
      M_STATUS: begin
        flush_o     = 1'b1;
        write_v_o   = 1'b1;
        adr_write_o = ADR_MSTATUS;
        data_o      = status_mret;
        state_next  = REDIRECT;
      end
      C_READ: begin
        adr_read_o = adr_q;
        state_next = C_WRITE;
      end
      C_WRITE: begin
        csr_done_o  = 1'b1;
        csr_rdata_o = old_q;
        csr_err_o   = wr_attempt && adr_ro;
        write_v_o   = wr_attempt && !adr_ro;
        adr_write_o = adr_q;
        data_o      = (wr_attempt && !adr_ro) ? csr_new : '0;
        state_next  = IDLE;
      end
      REDIRECT: begin
        // mtvec/mepc are sampled here so CSR writes done before the accept count.
        flush_o       = 1'b1;
        redirect_v_o  = 1'b1;
        redirect_pc_o = mret_q ? mepc_q_i : (mtvec_q_i & ~XLEN'(3));
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl with a tiny CSR-file read stub.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        commit_v, commit_mret;
  logic [5:0]  commit_exc;
  logic [31:0] commit_pc, commit_tval;
  logic        commit_ready;
  logic        csr_req_v, csr_nowrite;
  logic [1:0]  csr_op;
  logic [11:0] csr_adr;
  logic [31:0] csr_wdata;
  logic        csr_ready, csr_done, csr_err;
  logic [31:0] csr_rdata;
  logic        exception;
  logic [31:0] mcause, mtval, mepc;
  logic        write_v;
  logic [11:0] adr_write, adr_read;
  logic [31:0] data;
  logic [31:0] csr_data, mepc_q, mtvec_q;
  logic        flush, redirect_v;
  logic [31:0] redirect_pc;

  logic [31:0] mstatus_m, mscratch_m, mvendor_m;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  assign csr_data = (adr_read == 12'h300) ? mstatus_m  :
                    (adr_read == 12'h340) ? mscratch_m :
                    (adr_read == 12'hF11) ? mvendor_m  : 32'h0;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .commit_v_i(commit_v), .commit_exc_i(commit_exc), .commit_mret_i(commit_mret),
    .commit_pc_i(commit_pc), .commit_tval_i(commit_tval), .commit_ready_o(commit_ready),
    .csr_req_v_i(csr_req_v), .csr_op_i(csr_op), .csr_adr_i(csr_adr),
    .csr_wdata_i(csr_wdata), .csr_nowrite_i(csr_nowrite), .csr_ready_o(csr_ready),
    .csr_done_o(csr_done), .csr_rdata_o(csr_rdata), .csr_err_o(csr_err),
    .exception_o(exception), .mcause_o(mcause), .mtval_o(mtval), .mepc_o(mepc),
    .write_v_o(write_v), .adr_write_o(adr_write), .adr_read_o(adr_read), .data_o(data),
    .csr_data_i(csr_data), .mepc_q_i(mepc_q), .mtvec_q_i(mtvec_q),
    .flush_o(flush), .redirect_v_o(redirect_v), .redirect_pc_o(redirect_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    commit_v = 1'b0; commit_mret = 1'b0; commit_exc = '0;
    commit_pc = '0; commit_tval = '0;
    csr_req_v = 1'b0; csr_op = '0; csr_adr = '0; csr_wdata = '0; csr_nowrite = 1'b0;
  endtask

  // Trap with given flags; checks accept, cause cycle, status write and redirect.
  task automatic run_trap(input string tag, input logic [5:0] exc, input logic [31:0] pc,
                          input logic [31:0] tval, input logic [31:0] exp_cause,
                          input logic [31:0] exp_tval, input logic [31:0] exp_status,
                          input logic [31:0] exp_pc);
    commit_v = 1'b1; commit_exc = exc; commit_pc = pc; commit_tval = tval;
    #1;
    check({tag, ".ready"}, 32'(commit_ready), 32'd1);
    tick();
    clear_inputs();
    check({tag, ".c1_adr_read"}, 32'(adr_read), 32'h300);
    check({tag, ".c1_flush"}, 32'(flush), 32'd1);
    tick();
    check({tag, ".c2_exception"}, 32'(exception), 32'd1);
    check({tag, ".c2_mcause"}, mcause, exp_cause);
    check({tag, ".c2_mepc"}, mepc, pc);
    check({tag, ".c2_mtval"}, mtval, exp_tval);
    check({tag, ".c2_data"}, data, 32'h0);
    tick();
    check({tag, ".c3_write_v"}, 32'(write_v), 32'd1);
    check({tag, ".c3_adr_write"}, 32'(adr_write), 32'h300);
    check({tag, ".c3_data"}, data, exp_status);
    tick();
    check({tag, ".c4_redirect_v"}, 32'(redirect_v), 32'd1);
    check({tag, ".c4_redirect_pc"}, redirect_pc, exp_pc);
    tick();
    check({tag, ".c5_redirect_v"}, 32'(redirect_v), 32'd0);
    check({tag, ".c5_flush"}, 32'(flush), 32'd0);
  endtask

  // Zicsr request; checks accept, read address and completion cycle.
  task automatic run_csr(input string tag, input logic [1:0] op, input logic [11:0] adr,
                         input logic [31:0] wdata, input logic nowrite,
                         input logic [31:0] exp_rdata, input logic exp_wv,
                         input logic [31:0] exp_data, input logic exp_err);
    csr_req_v = 1'b1; csr_op = op; csr_adr = adr; csr_wdata = wdata; csr_nowrite = nowrite;
    #1;
    check({tag, ".ready"}, 32'(csr_ready), 32'd1);
    tick();
    clear_inputs();
    check({tag, ".c1_adr_read"}, 32'(adr_read), 32'(adr));
    check({tag, ".c1_flush"}, 32'(flush), 32'd0);
    tick();
    check({tag, ".c2_done"}, 32'(csr_done), 32'd1);
    check({tag, ".c2_rdata"}, csr_rdata, exp_rdata);
    check({tag, ".c2_write_v"}, 32'(write_v), 32'(exp_wv));
    check({tag, ".c2_err"}, 32'(csr_err), 32'(exp_err));
    if (exp_wv) begin
      check({tag, ".c2_adr_write"}, 32'(adr_write), 32'(adr));
      check({tag, ".c2_data"}, data, exp_data);
    end
    tick();
    check({tag, ".c3_done"}, 32'(csr_done), 32'd0);
  endtask

  initial begin
    clear_inputs();
    mstatus_m = 32'h8; mscratch_m = 32'hF0; mvendor_m = 32'h0000_5A5A;
    mepc_q = 32'h84; mtvec_q = 32'h101;
    reset = 1'b1;
    tick();
    tick();
    check("rst.commit_ready", 32'(commit_ready), 32'd0);
    check("rst.write_v", 32'(write_v), 32'd0);
    check("rst.exception", 32'(exception), 32'd0);
    check("rst.flush", 32'(flush), 32'd0);
    check("rst.redirect_v", 32'(redirect_v), 32'd0);
    check("rst.data", data, 32'h0);
    check("rst.csr_done", 32'(csr_done), 32'd0);
    reset = 1'b0;
    tick();

    // ecall: mcause 11, mtval 0, MIE -> MPIE, redirect to mtvec with mode bits cleared
    run_trap("ecall", 6'b000100, 32'h80, 32'h1234, 32'd11, 32'h0, 32'h1880, 32'h100);
    // illegal wins over load_misaligned
    mstatus_m = 32'h0;
    run_trap("illegal", 6'b010010, 32'h90, 32'hDEAD, 32'd2, 32'hDEAD, 32'h1800, 32'h100);
    // ebreak: mtval = pc
    run_trap("ebreak", 6'b001000, 32'hA0, 32'h77, 32'd3, 32'hA0, 32'h1800, 32'h100);
    // store_misaligned wins over load_misaligned
    run_trap("store_mis", 6'b110000, 32'hB0, 32'h55, 32'd6, 32'h55, 32'h1800, 32'h100);
    // fetch_misaligned has top priority
    run_trap("fetch_mis", 6'b111111, 32'hC0, 32'h66, 32'd0, 32'h66, 32'h1800, 32'h100);

    // mret: mstatus 0x1880 -> 0x1888, redirect to mepc in cycle 3
    mstatus_m = 32'h1880;
    commit_v = 1'b1; commit_mret = 1'b1;
    #1;
    check("mret.ready", 32'(commit_ready), 32'd1);
    tick();
    clear_inputs();
    check("mret.c1_adr_read", 32'(adr_read), 32'h300);
    check("mret.c1_flush", 32'(flush), 32'd1);
    tick();
    check("mret.c2_write_v", 32'(write_v), 32'd1);
    check("mret.c2_data", data, 32'h1888);
    check("mret.c2_exception", 32'(exception), 32'd0);
    tick();
    check("mret.c3_redirect_v", 32'(redirect_v), 32'd1);
    check("mret.c3_redirect_pc", redirect_pc, 32'h84);
    tick();
    check("mret.c4_redirect_v", 32'(redirect_v), 32'd0);

    // Zicsr
    run_csr("csrrs", 2'b10, 12'h340, 32'h0F, 1'b0, 32'hF0, 1'b1, 32'hFF, 1'b0);
    run_csr("csrrs_nw", 2'b10, 12'h340, 32'h0F, 1'b1, 32'hF0, 1'b0, 32'h0, 1'b0);
    mscratch_m = 32'hFF;
    run_csr("csrrc", 2'b11, 12'h340, 32'h0F, 1'b0, 32'hFF, 1'b1, 32'hF0, 1'b0);
    run_csr("csrrw", 2'b01, 12'h340, 32'h1234_5678, 1'b0, 32'hFF, 1'b1, 32'h1234_5678, 1'b0);
    run_csr("op00_rs", 2'b00, 12'h340, 32'h100, 1'b0, 32'hFF, 1'b1, 32'h1FF, 1'b0);
    run_csr("csrrw_ro", 2'b01, 12'hF11, 32'h1, 1'b0, 32'h5A5A, 1'b0, 32'h0, 1'b1);

    // trap and CSR request together: trap first, CSR accepted in cycle 5, done in 7
    mstatus_m = 32'h8; mscratch_m = 32'h3;
    commit_v = 1'b1; commit_exc = 6'b000100; commit_pc = 32'h200;
    csr_req_v = 1'b1; csr_op = 2'b10; csr_adr = 12'h340; csr_wdata = 32'h4;
    #1;
    check("arb.c0_commit_ready", 32'(commit_ready), 32'd1);
    check("arb.c0_csr_ready", 32'(csr_ready), 32'd0);
    tick();
    commit_v = 1'b0; commit_exc = '0;
    for (int unsigned c = 1; c <= 4; c++) begin
      check($sformatf("arb.c%0d_csr_ready", c), 32'(csr_ready), 32'd0);
      tick();
    end
    check("arb.c5_csr_ready", 32'(csr_ready), 32'd1);
    tick();
    clear_inputs();
    check("arb.c6_adr_read", 32'(adr_read), 32'h340);
    tick();
    check("arb.c7_done", 32'(csr_done), 32'd1);
    check("arb.c7_data", data, 32'h7);
    tick();

    // reset asserted in T_CAUSE aborts the trap without redirect
    commit_v = 1'b1; commit_exc = 6'b000100; commit_pc = 32'h300;
    tick();
    clear_inputs();
    tick();
    check("rmid.c2_exception", 32'(exception), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rmid.c3_write_v", 32'(write_v), 32'd0);
    check("rmid.c3_flush", 32'(flush), 32'd0);
    check("rmid.c3_exception", 32'(exception), 32'd0);
    tick();
    check("rmid.c4_redirect_v", 32'(redirect_v), 32'd0);
    check("rmid.c4_flush", 32'(flush), 32'd0);
    csr_req_v = 1'b1; csr_op = 2'b10; csr_adr = 12'h340; csr_nowrite = 1'b1;
    #1;
    check("rmid.idle_csr_ready", 32'(csr_ready), 32'd1);
    tick();
    clear_inputs();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
